// File: rtl/ps2_key_tracker_if.sv
// Pop handshake between the PS/2 keyboard byte FIFO (master) and its consumer (slave).
interface ps2_key_tracker_if;
    logic [7:0] ps2_data_in;
    logic       ps2_ready;
    logic       ps2_overflow;
    logic       ps2_nextdata_n;

    modport master (output ps2_data_in, ps2_ready, ps2_overflow, input ps2_nextdata_n);
    modport slave  (input ps2_data_in, ps2_ready, ps2_overflow, output ps2_nextdata_n);
endinterface

// File: rtl/ps2_key_tracker.sv
// Set-2 make/break decoder with held-key tracking, typematic filtering, press counter and 7-seg display.
// Optional ASCII_EN macro adds a Set-2 to ASCII table shown on digits 2-3.
module ps2_key_tracker #(
    parameter int NUM_DIGITS = 6,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    ps2_key_tracker_if.slave        kbd,
    output logic [7:0]              key_code,
    output logic                    key_ext,
    output logic                    key_down,
    output logic                    key_event,
    output logic [CNT_W-1:0]        press_count,
    output logic                    ovf_sticky,
    output logic [8*NUM_DIGITS-1:0] seg_out
);
    localparam int CNT_DIGITS = NUM_DIGITS - 4;
    localparam int PAD_W      = (CNT_DIGITS > 0) ? 4 * CNT_DIGITS : 4;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
    state_t state, state_next;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
        endcase
    endfunction

`ifdef ASCII_EN
    // Returns 0 for codes without a printable mapping.
    function automatic logic [7:0] set2_ascii(input logic [7:0] code);
        case (code)
            8'h1C: set2_ascii = 8'h61;  8'h32: set2_ascii = 8'h62;  8'h21: set2_ascii = 8'h63;
            8'h23: set2_ascii = 8'h64;  8'h24: set2_ascii = 8'h65;  8'h2B: set2_ascii = 8'h66;
            8'h34: set2_ascii = 8'h67;  8'h33: set2_ascii = 8'h68;  8'h43: set2_ascii = 8'h69;
            8'h3B: set2_ascii = 8'h6A;  8'h42: set2_ascii = 8'h6B;  8'h4B: set2_ascii = 8'h6C;
            8'h3A: set2_ascii = 8'h6D;  8'h31: set2_ascii = 8'h6E;  8'h44: set2_ascii = 8'h6F;
            8'h4D: set2_ascii = 8'h70;  8'h15: set2_ascii = 8'h71;  8'h2D: set2_ascii = 8'h72;
            8'h1B: set2_ascii = 8'h73;  8'h2C: set2_ascii = 8'h74;  8'h3C: set2_ascii = 8'h75;
            8'h2A: set2_ascii = 8'h76;  8'h1D: set2_ascii = 8'h77;  8'h22: set2_ascii = 8'h78;
            8'h35: set2_ascii = 8'h79;  8'h1A: set2_ascii = 8'h7A;  8'h45: set2_ascii = 8'h30;
            8'h16: set2_ascii = 8'h31;  8'h1E: set2_ascii = 8'h32;  8'h26: set2_ascii = 8'h33;
            8'h25: set2_ascii = 8'h34;  8'h2E: set2_ascii = 8'h35;  8'h36: set2_ascii = 8'h36;
            8'h3D: set2_ascii = 8'h37;  8'h3E: set2_ascii = 8'h38;  8'h46: set2_ascii = 8'h39;
            8'h29: set2_ascii = 8'h20;
            default: set2_ascii = 8'h00;
        endcase
    endfunction
`endif

    // Stage p0: byte capture and sequence decode
    logic       vld_p0;
    logic [7:0] byte_p0;
    logic       make_p0, brk_p0, ext_p0;
    logic       same_key, new_make, rel_match;

    assign vld_p0    = kbd.ps2_ready & kbd.ps2_nextdata_n;
    assign byte_p0   = kbd.ps2_data_in;
    assign same_key  = ({ext_p0, byte_p0} == {key_ext, key_code});
    assign new_make  = make_p0 & ~(key_down & same_key);
    assign rel_match = brk_p0 & same_key;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        make_p0    = 1'b0;
        brk_p0     = 1'b0;
        ext_p0     = 1'b0;
        if (vld_p0) begin
            case (state)
                IDLE: begin
                    if (byte_p0 == 8'hE0)      state_next = EXT;
                    else if (byte_p0 == 8'hF0) state_next = BRK;
                    else                       make_p0 = 1'b1;
                end
                EXT: begin
                    ext_p0 = 1'b1;
                    if (byte_p0 == 8'hF0) begin
                        state_next = EXT_BRK;
                    end else if (byte_p0 != 8'hE0) begin
                        make_p0    = 1'b1;
                        state_next = IDLE;
                    end
                end
                BRK: begin
                    brk_p0     = 1'b1;
                    state_next = IDLE;
                end
                EXT_BRK: begin
                    ext_p0     = 1'b1;
                    brk_p0     = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Stage p1: held-key state, counter and pop strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kbd.ps2_nextdata_n <= 1'b1;
            key_code           <= 8'h00;
            key_ext            <= 1'b0;
            key_down           <= 1'b0;
            key_event          <= 1'b0;
            press_count        <= '0;
            ovf_sticky         <= 1'b0;
        end else begin
            kbd.ps2_nextdata_n <= ~vld_p0;
            key_event          <= new_make;
            if (kbd.ps2_overflow) ovf_sticky <= 1'b1;
            if (new_make) begin
                key_code    <= byte_p0;
                key_ext     <= ext_p0;
                key_down    <= 1'b1;
                press_count <= press_count + CNT_W'(1);
            end else if (rel_match) begin
                key_down <= 1'b0;
            end
        end
    end

    // Stage p2: registered display, one cycle behind the key state
    logic [PAD_W-1:0]        cnt_pad;
    logic [8*NUM_DIGITS-1:0] seg_next;
`ifdef ASCII_EN
    logic [7:0]              ascii;
    assign ascii = set2_ascii(key_code);
`endif

    always_comb begin
        cnt_pad  = PAD_W'(press_count);
        seg_next = '1;
        if (key_down) begin
            seg_next[7:0]  = hex7(key_code[3:0]);
            seg_next[15:8] = hex7(key_code[7:4]);
        end
`ifdef ASCII_EN
        if (key_down && !key_ext && ascii != 8'h00) begin
            seg_next[23:16] = hex7(ascii[3:0]);
            seg_next[31:24] = hex7(ascii[7:4]);
        end
`endif
        for (int k = 0; k < CNT_DIGITS; k++)
            seg_next[8*(4+k) +: 8] = hex7(cnt_pad[4*k +: 4]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) seg_out <= '1;
        else     seg_out <= seg_next;
    end
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomized bench for ps2_key_tracker against a sequence-level behavioural model.
module tb_ps2_key_tracker;
    localparam int ND = 6;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      key_code;
    logic            key_ext, key_down, key_event, ovf_sticky;
    logic [CW-1:0]   press_count;
    logic [8*ND-1:0] seg_out;

    ps2_key_tracker_if kbd();

    ps2_key_tracker #(.NUM_DIGITS(ND), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .kbd        (kbd),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_down   (key_down),
        .key_event  (key_event),
        .press_count(press_count),
        .ovf_sticky (ovf_sticky),
        .seg_out    (seg_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int events = 0;
    int b2b    = 0;
    bit prev_low = 1'b0;
    bit random_ready = 1'b0;
    logic [7:0] fifo [$];

    logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [7:0] pool [14] = '{8'h1C, 8'h1C, 8'h32, 8'h75, 8'h6B, 8'h29, 8'h16,
                              8'h45, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h74, 8'h5A};

`ifdef ASCII_EN
    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    function automatic int ascii_of(input logic [7:0] c);
        for (int i = 0; i < 26; i++) if (letter_codes[i] == c) return 97 + i;
        for (int i = 0; i < 10; i++) if (digit_codes[i] == c) return 48 + i;
        if (c == 8'h29) return 32;
        return 0;
    endfunction
`endif

    // Behavioural model: bytes collect into a pending prefix list until a sequence completes
    logic            m_nd    = 1'b1;
    logic [7:0]      m_code  = 8'h00;
    logic            m_ext   = 1'b0;
    logic            m_down  = 1'b0;
    logic            m_event = 1'b0;
    logic [CW-1:0]   m_count = '0;
    logic            m_ovf   = 1'b0;
    logic [8*ND-1:0] m_seg   = '1;
    logic [7:0]      m_seq [$];

    function automatic logic [8*ND-1:0] exp_seg();
        logic [8*ND-1:0] s = '1;
        int c = int'(m_count);
        if (m_down) begin
            s[7:0]  = font[m_code[3:0]];
            s[15:8] = font[m_code[7:4]];
        end
`ifdef ASCII_EN
        begin
            int a = ascii_of(m_code);
            if (m_down && !m_ext && a != 0) begin
                s[23:16] = font[4'(a % 16)];
                s[31:24] = font[4'(a / 16)];
            end
        end
`endif
        for (int k = 0; k < ND - 4; k++) s[8*(4+k) +: 8] = font[4'((c >> (4*k)) & 15)];
        return s;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        bit has_e0 = 1'b0;
        bit has_f0 = 1'b0;
        foreach (m_seq[i]) begin
            if (m_seq[i] == 8'hE0) has_e0 = 1'b1;
            if (m_seq[i] == 8'hF0) has_f0 = 1'b1;
        end
        if (has_f0 || (b != 8'hE0 && b != 8'hF0)) begin
            m_seq.delete();
            if (has_f0) begin
                if (has_e0 == m_ext && b == m_code) m_down = 1'b0;
            end else if (!(m_down && has_e0 == m_ext && b == m_code)) begin
                m_code  = b;
                m_ext   = has_e0;
                m_down  = 1'b1;
                m_count = m_count + CW'(1);
                m_event = 1'b1;
            end
        end else begin
            m_seq.push_back(b);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_nd = 1'b1; m_code = 8'h00; m_ext = 1'b0; m_down = 1'b0; m_event = 1'b0;
            m_count = '0; m_ovf = 1'b0; m_seg = '1;
            m_seq.delete();
        end else begin
            m_seg   = exp_seg();
            m_event = 1'b0;
            if (kbd.ps2_overflow) m_ovf = 1'b1;
            if (kbd.ps2_ready && m_nd) begin
                m_nd = 1'b0;
                model_byte(kbd.ps2_data_in);
            end else begin
                m_nd = 1'b1;
            end
        end
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] digit(input int i);
        return seg_out[8*i +: 8];
    endfunction

    always @(negedge clk) begin
        chk("nextdata_n", 64'(kbd.ps2_nextdata_n), 64'(m_nd));
        chk("key_code", 64'(key_code), 64'(m_code));
        chk("key_ext", 64'(key_ext), 64'(m_ext));
        chk("key_down", 64'(key_down), 64'(m_down));
        chk("key_event", 64'(key_event), 64'(m_event));
        chk("press_count", 64'(press_count), 64'(m_count));
        chk("ovf_sticky", 64'(ovf_sticky), 64'(m_ovf));
        chk("seg_out", 64'(seg_out), 64'(m_seg));
        if (!kbd.ps2_nextdata_n) pops++;
        if (!kbd.ps2_nextdata_n && prev_low) b2b++;
        prev_low = !kbd.ps2_nextdata_n;
        if (key_event) events++;
    end

    // Keyboard FIFO: head byte is removed on the edge after the consumer pulls nextdata_n low
    initial begin
        logic nd_seen;
        kbd.ps2_ready    = 1'b0;
        kbd.ps2_data_in  = 8'h00;
        kbd.ps2_overflow = 1'b0;
        forever begin
            @(negedge clk);
            nd_seen = kbd.ps2_nextdata_n;
            @(posedge clk);
            #1;
            if (!nd_seen && fifo.size() > 0) void'(fifo.pop_front());
            if (fifo.size() > 0 && (!random_ready || $urandom_range(0, 3) != 0)) begin
                kbd.ps2_ready   = 1'b1;
                kbd.ps2_data_in = fifo[0];
            end else begin
                kbd.ps2_ready   = 1'b0;
                kbd.ps2_data_in = 8'($urandom_range(0, 255));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (fifo.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL drain_%s: %0d bytes left in fifo, expected 0", tag, fifo.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic ovf_pulse();
        @(posedge clk);
        #1 kbd.ps2_overflow = 1'b1;
        @(posedge clk);
        #1 kbd.ps2_overflow = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int ev0, p0;
        repeat (2) @(negedge clk);
        chk("rst_seg", 64'(seg_out), 64'({ND{8'hFF}}));
        chk("rst_nextdata_n", 64'(kbd.ps2_nextdata_n), 64'h1);
        chk("rst_count", 64'(press_count), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: single make
        ev0 = events;
        send(8'h1C);
        drain("t1");
        chk("t1_code", 64'(key_code), 64'h1C);
        chk("t1_down", 64'(key_down), 64'h1);
        chk("t1_count", 64'(press_count), 64'h1);
        chk("t1_events", 64'(events - ev0), 64'h1);
        chk("t1_dig0", 64'(digit(0)), 64'hC6);
        chk("t1_dig1", 64'(digit(1)), 64'hF9);
        chk("t1_dig4", 64'(digit(4)), 64'hF9);
        chk("t1_dig5", 64'(digit(5)), 64'hC0);
`ifdef ASCII_EN
        chk("t1_dig2", 64'(digit(2)), 64'hF9);
        chk("t1_dig3", 64'(digit(3)), 64'h82);
`else
        chk("t1_dig2", 64'(digit(2)), 64'hFF);
        chk("t1_dig3", 64'(digit(3)), 64'hFF);
`endif

        // 2: typematic repeats
        repeat (3) send(8'h1C);
        drain("t2");
        chk("t2_count", 64'(press_count), 64'h1);
        chk("t2_events", 64'(events - ev0), 64'h1);
        chk("t2_down", 64'(key_down), 64'h1);

        // 3: release
        send(8'hF0); send(8'h1C);
        drain("t3");
        chk("t3_down", 64'(key_down), 64'h0);
        chk("t3_dig03", 64'(seg_out[31:0]), 64'hFFFF_FFFF);
        chk("t3_dig4", 64'(digit(4)), 64'hF9);
        chk("t3_dig5", 64'(digit(5)), 64'hC0);

        // 4: extended make and release
        send(8'hE0); send(8'h75);
        drain("t4a");
        chk("t4_ext", 64'(key_ext), 64'h1);
        chk("t4_code", 64'(key_code), 64'h75);
        chk("t4_count", 64'(press_count), 64'h2);
        chk("t4_dig0", 64'(digit(0)), 64'h92);
        chk("t4_dig1", 64'(digit(1)), 64'hF8);
        chk("t4_dig23", 64'(seg_out[31:16]), 64'hFFFF);
        send(8'hE0); send(8'hF0); send(8'h75);
        drain("t4b");
        chk("t4_released", 64'(key_down), 64'h0);

        // 5: back-to-back bytes pop on alternate cycles
        p0 = pops;
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        drain("t5");
        chk("t5_pops", 64'(pops - p0), 64'h4);
        chk("t5_b2b", 64'(b2b), 64'h0);
        chk("t5_count", 64'(press_count), 64'h6);

        // 6: sticky overflow, reset mid-sequence
        ovf_pulse();
        repeat (4) @(negedge clk);
        chk("t6_ovf", 64'(ovf_sticky), 64'h1);
        send(8'hE0);
        drain("t6a");
        do_reset();
        @(negedge clk);
        chk("t6_ovf_clr", 64'(ovf_sticky), 64'h0);
        send(8'h1C);
        drain("t6b");
        chk("t6_ext", 64'(key_ext), 64'h0);
        chk("t6_count", 64'(press_count), 64'h1);
        chk("t6_code", 64'(key_code), 64'h1C);

        // Random traffic
        random_ready = 1'b1;
        for (int it = 0; it < 400; it++) begin
            int len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 7) == 0) send(8'($urandom_range(0, 255)));
                else send(pool[$urandom_range(0, 13)]);
            end
            if ($urandom_range(0, 15) == 0) ovf_pulse();
            if ($urandom_range(0, 24) == 0) do_reset();
            drain("rand");
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end
        chk("final_b2b", 64'(b2b), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
